// File: rtl/sspis_pkg.sv
// Shared types and constants for the SPI-slave to register-bus bridge.
package sspis_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_WR_REQ,
    ST_RD_REQ,
    ST_TURN,
    ST_RDATA,
    ST_DONE
  } state_t;

  localparam logic [3:0]  OP_WR      = 4'h1;
  localparam logic [3:0]  OP_RD      = 4'h2;
  localparam int unsigned DUMMY_BITS = 8;
  localparam int unsigned CMD_BITS   = 8;
  localparam int unsigned WORD_BITS  = 32;

  // True for the opcodes that start a bus transaction.
  function automatic logic op_valid(input logic [3:0] op);
    return (op == OP_WR) || (op == OP_RD);
  endfunction

endpackage

// File: rtl/sspis_sync.sv
// Pad synchronizer with rise/fall detect; edges are suppressed until the
// pipeline holds real pad samples so reset values never look like edges.
module sspis_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic mclk,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] sync_r;
  logic              prev_r;
  logic [STAGES:0]   vld_r;

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= {STAGES{RST_VAL}};
      prev_r <= RST_VAL;
      vld_r  <= '0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
      prev_r <= sync_r[STAGES-1];
      vld_r  <= {vld_r[STAGES-1:0], 1'b1};
    end
  end

  assign q      = sync_r[STAGES-1];
  assign rise_c = vld_r[STAGES] &  q & ~prev_r;
  assign fall_c = vld_r[STAGES] & ~q &  prev_r;

endmodule

// File: rtl/sspis_if.sv
// SPI mode-0 slave that turns {cmd, addr, data} frames into register-bus
// write/read requests, returning read data after a dummy byte.
module sspis_if
  import sspis_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        mclk,
  input  logic        reset_n,
  input  logic        sclk,
  input  logic        ssn,
  input  logic        sdin,
  output logic        sdout,
  output logic        sdout_oen,
  output logic        reg_cs,
  output logic        reg_wr,
  output logic [31:0] reg_addr,
  output logic [3:0]  reg_be,
  output logic [31:0] reg_wdata,
  input  logic [31:0] reg_rdata,
  input  logic        reg_ack
);

  logic sclk_q, sclk_rise_c, sclk_fall_c;
  logic ssn_q, ssn_rise_c, ssn_fall_c;
  logic sdin_q, sdin_rise_c, sdin_fall_c;
  logic sync_unused_c;

  sspis_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .mclk(mclk), .reset_n(reset_n), .d(sclk),
    .q(sclk_q), .rise_c(sclk_rise_c), .fall_c(sclk_fall_c)
  );

  sspis_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ssn (
    .mclk(mclk), .reset_n(reset_n), .d(ssn),
    .q(ssn_q), .rise_c(ssn_rise_c), .fall_c(ssn_fall_c)
  );

  sspis_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdin (
    .mclk(mclk), .reset_n(reset_n), .d(sdin),
    .q(sdin_q), .rise_c(sdin_rise_c), .fall_c(sdin_fall_c)
  );

  assign sync_unused_c = ^{sclk_q, sdin_rise_c, sdin_fall_c};

  state_t      state;
  logic [5:0]  bit_cnt;
  logic [31:0] rx_sr;
  logic [31:0] tx_sr;
  logic [31:0] addr_q;
  logic [3:0]  op_q;
  logic [3:0]  be_q;
  logic        req_own;
  logic        rd_have;
  logic        rd_late;

  logic [31:0] rx_next_c;
  logic [31:0] rd_data_c;
  logic        ack_c;
  logic        cap_c;
  logic        last_word_c;

  // req_own marks a pending request that belongs to the current frame.
  assign rx_next_c   = {rx_sr[30:0], sdin_q};
  assign ack_c       = reg_cs & reg_ack;
  assign cap_c       = ack_c & req_own & ~reg_wr;
  assign rd_data_c   = cap_c ? reg_rdata : tx_sr;
  assign last_word_c = (bit_cnt == 6'(WORD_BITS - 1));

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      addr_q    <= '0;
      op_q      <= '0;
      be_q      <= '0;
      req_own   <= 1'b0;
      rd_have   <= 1'b0;
      rd_late   <= 1'b0;
      sdout     <= 1'b0;
      sdout_oen <= 1'b1;
      reg_cs    <= 1'b0;
      reg_wr    <= 1'b0;
      reg_addr  <= '0;
      reg_be    <= '0;
      reg_wdata <= '0;
    end else begin
      sdout_oen <= ssn_q;

      // A request is never aborted: it only ends one cycle after its ack.
      if (ack_c) begin
        reg_cs  <= 1'b0;
        reg_wr  <= 1'b0;
        req_own <= 1'b0;
      end
      if (cap_c) begin
        tx_sr   <= reg_rdata;
        rd_have <= 1'b1;
      end

      if (ssn_rise_c) begin
        state   <= ST_IDLE;
        bit_cnt <= '0;
        req_own <= 1'b0;
      end else begin
        if (sclk_fall_c && (state inside {ST_CMD, ST_ADDR, ST_WDATA, ST_RD_REQ, ST_TURN}))
          sdout <= 1'b0;

        case (state)
          ST_IDLE: begin
            if (ssn_fall_c) begin
              state   <= ST_CMD;
              bit_cnt <= '0;
              rd_late <= 1'b0;
              rd_have <= 1'b0;
            end
          end

          ST_CMD: begin
            if (sclk_rise_c) begin
              rx_sr <= rx_next_c;
              if (bit_cnt == 6'(CMD_BITS - 1)) begin
                op_q    <= rx_next_c[7:4];
                be_q    <= rx_next_c[3:0];
                bit_cnt <= '0;
                state   <= op_valid(rx_next_c[7:4]) ? ST_ADDR : ST_DONE;
              end else begin
                bit_cnt <= bit_cnt + 6'd1;
              end
            end
          end

          ST_ADDR: begin
            if (sclk_rise_c) begin
              rx_sr <= rx_next_c;
              if (last_word_c) begin
                addr_q  <= rx_next_c;
                bit_cnt <= '0;
                state   <= (op_q == OP_WR) ? ST_WDATA : ST_RD_REQ;
                if (!reg_cs) begin
                  reg_addr <= rx_next_c;
                  reg_be   <= be_q;
                end
              end else begin
                bit_cnt <= bit_cnt + 6'd1;
              end
            end
          end

          ST_WDATA: begin
            if (sclk_rise_c) begin
              rx_sr <= rx_next_c;
              if (last_word_c) begin
                state   <= ST_WR_REQ;
                bit_cnt <= '0;
              end else begin
                bit_cnt <= bit_cnt + 6'd1;
              end
            end
          end

          ST_WR_REQ: begin
            if (!reg_cs) begin
              reg_cs    <= 1'b1;
              reg_wr    <= 1'b1;
              reg_addr  <= addr_q;
              reg_be    <= be_q;
              reg_wdata <= rx_sr;
              req_own   <= 1'b1;
            end else if (ack_c && req_own) begin
              state   <= ST_DONE;
              bit_cnt <= '0;
            end
          end

          ST_RD_REQ: begin
            if (!reg_cs) begin
              reg_cs   <= 1'b1;
              reg_wr   <= 1'b0;
              reg_addr <= addr_q;
              reg_be   <= be_q;
              req_own  <= 1'b1;
              state    <= ST_TURN;
              bit_cnt  <= '0;
            end
          end

          ST_TURN: begin
            if (sclk_rise_c) begin
              if (bit_cnt == 6'(DUMMY_BITS - 1)) begin
                state   <= ST_RDATA;
                bit_cnt <= '0;
              end else begin
                bit_cnt <= bit_cnt + 6'd1;
              end
            end
          end

          ST_RDATA: begin
            // No data by the first shift-out edge: send zeros and flag it.
            if (sclk_fall_c) begin
              if ((bit_cnt == '0) && !rd_have && !cap_c) begin
                rd_late <= 1'b1;
                req_own <= 1'b0;
                sdout   <= 1'b0;
                tx_sr   <= '0;
              end else begin
                sdout <= rd_data_c[31];
                tx_sr <= {rd_data_c[30:0], 1'b0};
              end
            end
            if (sclk_rise_c) begin
              if (last_word_c) begin
                state   <= ST_DONE;
                bit_cnt <= '0;
              end else begin
                bit_cnt <= bit_cnt + 6'd1;
              end
            end
          end

          ST_DONE: begin
          end

          default: begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule
